// File: rtl/lcd_nibble_ctrl.sv
// HD44780 4-bit write sequencer: one byte per valid/ready handshake, sent as two timed nibbles.
// Latency: accept edge to req_ready=1 is 2*(SETUP+E_HIGH+E_LOW)+WAIT cycles (WAIT = CLR or CMD).
// Backpressure: req_ready is high only in IDLE; the byte is latched at accept, later input changes are ignored.
// Optional power-on init sequence: define LCD_INIT_EN.
module lcd_nibble_ctrl #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_HIGH_CYC    = 13,
  parameter int unsigned E_LOW_CYC     = 13,
  parameter int unsigned CMD_WAIT_CYC  = 1080,
  parameter int unsigned CLR_WAIT_CYC  = 43200,
  parameter int unsigned INIT_WAIT_CYC = 1080000,
  parameter int unsigned INIT_STEP_CYC = 111000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(E_LOW_CYC, CMD_WAIT_CYC)),
                                         max2(CLR_WAIT_CYC, max2(INIT_WAIT_CYC, INIT_STEP_CYC)));
  localparam int CW = $clog2(MAX_CYC) + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LD_SETUP = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t LD_EHIGH = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t LD_ELOW  = cnt_t'(E_LOW_CYC - 1);
  localparam cnt_t LD_CMD   = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t LD_CLR   = cnt_t'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
  localparam cnt_t LD_IWAIT = cnt_t'(INIT_WAIT_CYC - 1);
  localparam cnt_t LD_ISTEP = cnt_t'(INIT_STEP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EHIGH, S_ELOW, S_WAIT
`ifdef LCD_INIT_EN
    , S_INIT_DLY, S_INIT_NIB
`endif
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       nib_q, nib_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic [3:0] db_q, db_d;
  logic       e_q, e_d;
  logic       ready_q, ready_d;
`ifdef LCD_INIT_EN
  logic       init_q, init_d;
  logic [1:0] idx_q, idx_d;
`endif

  // Clear (0x01) and home (0x02/0x03) need the long execution wait; 0x00 does not.
  logic is_clr;
  assign is_clr = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // Next-state, counter reload on every state entry, and nibble selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    data_d  = data_q;
    db_d    = db_q;
`ifdef LCD_INIT_EN
    init_d  = init_q;
    idx_d   = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs_d    = req_rs;
          data_d  = req_data;
          db_d    = req_data[7:4];
          nib_d   = 1'b0;
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EHIGH;
          cnt_d   = LD_EHIGH;
        end
      end
      S_EHIGH: begin
        if (cnt_q == '0) begin
          state_d = S_ELOW;
          cnt_d   = LD_ELOW;
        end
      end
      S_ELOW: begin
        if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
          if (init_q) begin
            state_d = S_INIT_NIB;
            cnt_d   = (idx_q == 2'd3) ? LD_CMD : LD_ISTEP;
          end else
`endif
          if (!nib_q) begin
            nib_d   = 1'b1;
            db_d    = data_q[3:0];
            state_d = S_SETUP;
            cnt_d   = LD_SETUP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = is_clr ? LD_CLR : LD_CMD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
`ifdef LCD_INIT_EN
      S_INIT_DLY: begin
        if (cnt_q == '0) begin
          rs_d    = 1'b0;
          db_d    = 4'h3;
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      S_INIT_NIB: begin
        if (cnt_q == '0) begin
          if (idx_q == 2'd3) begin
            init_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            db_d    = (idx_q == 2'd2) ? 4'h2 : 4'h3;
            state_d = S_SETUP;
            cnt_d   = LD_SETUP;
          end
        end
      end
`endif
      default: state_d = state_q;
    endcase
    e_d     = (state_d == S_EHIGH);
    ready_d = (state_d == S_IDLE);
  end

  // State, counter, latched byte and registered pin drivers; reset aborts any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef LCD_INIT_EN
      state_q <= S_INIT_DLY;
      cnt_q   <= LD_IWAIT;
      ready_q <= 1'b0;
      init_q  <= 1'b1;
      idx_q   <= 2'd0;
`else
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
`endif
      nib_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      db_q    <= 4'h0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
`ifdef LCD_INIT_EN
      init_q  <= init_d;
      idx_q   <= idx_d;
`endif
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      db_q    <= db_d;
      e_q     <= e_d;
    end
  end

  assign req_ready = ready_q;
  assign lcd_e     = e_q;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = rs_q;
  assign lcd_db    = db_q;

endmodule
